time_set_ctrl: RTL
==================

# time_set_ctrl

Sequences time-setting for the clock while the mode selector reports mode 0 (modify). On entry it snapshots the live time into an edit buffer. It then walks the hour/minute/second fields on `btn_next` and steps the selected field with wrap-around on `btn_up`/`btn_down`, with auto-repeat while a button is held. On exit it issues a one-cycle load strobe to the timekeeper, but only if something was edited. It sits between the mode selector, the debounced buttons, the timekeeper and the display driver, which uses `field`/`blink`.

## Interface
Parameters:
- `HOLD_CYCLES`, default 50_000_000: cycles a step button must stay high after its edge before auto-repeat starts.
- `REPEAT_CYCLES`, default 10_000_000: cycles between auto-repeat steps.
- `BLINK_CYCLES`, default 25_000_000: half-period of the selected-field blink.

Ports:
- `clk` — input, 1 bit: single clock.
- `rst_n` — input, 1 bit: reset, synchronous, active-low.
- `mode` — input, 4 bits: current mode from the selector; setting is active when `mode == 0`.
- `btn_up`, `btn_down`, `btn_next` — input, 1 bit each: debounced, clk-synchronous button levels.
- `cur_hour` — input, 5 bits; `cur_min`, `cur_sec` — input, 6 bits each: live time from the timekeeper.
- `set_hour` — output, 5 bits; `set_min`, `set_sec` — output, 6 bits each: edit buffer, registered.
- `load` — output, 1 bit: one-cycle commit strobe to the timekeeper.
- `field` — output, 2 bits: 0 = none, 1 = hour, 2 = minute, 3 = second.
- `blink` — output, 1 bit: 1 = selected field visible, 0 = blanked.
- `editing` — output, 1 bit: high in the EDIT states.

## Operation
- States: IDLE, EDIT_H, EDIT_M, EDIT_S, COMMIT.
- Reset (`rst_n = 0` at a clk edge):
  - state goes to IDLE.
  - `set_*`, `load`, `field`, `editing`, `dirty` and all counters go to 0.
  - `blink` goes to 1.
  - Edge-detect registers go to 0.
- Reset mid-edit discards the buffer. No `load` is issued.
- IDLE:
  - Buttons are ignored.
  - When `mode == 0`: capture `cur_*` into `set_*`, clear `dirty`, go to EDIT_H.
- EDIT_x, `field` = 1/2/3:
  - A rising edge on `btn_next` advances H→M→S→H.
  - A rising edge on `btn_up` increments the selected field; a rising edge on `btn_down` decrements it.
  - Wrap: hour 23↔0, minute and second 59↔0.
  - Any step sets `dirty`.
  - Priority: `btn_next` edge beats a step in the same cycle.
  - `btn_up` and `btn_down` both high in the same cycle: no step, and the repeat counter is cleared.
- Auto-repeat:
  - The repeat counter counts while the stepping button stays continuously high.
  - Further steps occur at edge + `HOLD_CYCLES`, then every `REPEAT_CYCLES`.
  - Release, a field change or an exit clears the counter.
- Blink:
  - In EDIT states, `blink` toggles every `BLINK_CYCLES`.
  - Any step or field change forces `blink = 1` and restarts the blink counter.
  - In IDLE and COMMIT, `blink = 1`.
- Exit: `mode != 0` in an EDIT state → COMMIT if `dirty`, else IDLE.
- COMMIT:
  - `load = 1` for exactly one cycle, with `set_*` stable.
  - Then go to IDLE unconditionally, even if `mode` has already returned to 0.
- Edge-detect registers update every cycle in all states. A button held across entry to EDIT_H produces no edge.

## Timing
- All outputs are registered.
- `mode == 0` sampled at edge N in IDLE → from N+1: `set_* = cur_*` as of edge N, `editing = 1`, `field = 1`.
- Button rising edge sampled at edge N → new `set_*` / `field` visible from N+1.
- Held `btn_up` whose edge is at E: steps at E, E+`HOLD_CYCLES`, E+`HOLD_CYCLES`+`REPEAT_CYCLES`, and so on.
- `mode != 0` sampled at edge N in EDIT with `dirty` → `load = 1` during N+1 → IDLE, with `editing = 0` and `field = 0`, from N+2.
  - Without `dirty`: IDLE from N+1, no `load`.
- Re-entry: at the earliest, a capture at the first IDLE edge following exit.

## Test plan
- Sim parameters: `HOLD_CYCLES = 4`, `REPEAT_CYCLES = 2`, `BLINK_CYCLES = 3`.
- Entry/wrap: `cur` = 23:59:59, set `mode = 0`, pulse `btn_up` once per field (with `btn_next` between), then `mode = 3` → `set` = 00:00:00, `load` high exactly one cycle, then IDLE.
- Down wrap and no-change exit:
  - 00:00:00, `btn_down` on minute → `set_min = 59`.
  - Separate session with no presses → exit produces no `load`.
- Auto-repeat: `set_sec = 10`, `btn_up` held 9 cycles from edge E → steps at E, E+4, E+6, E+8 → `set_sec = 14`. Releasing stops the steps.
- Conflicts:
  - `btn_next` and `btn_up` rising in the same cycle → field advances, value unchanged.
  - `btn_up` and `btn_down` both high → no change.
- Blink and held entry:
  - Idle in EDIT → `blink` toggles every 3 cycles.
  - A step forces `blink = 1`.
  - `btn_up` held while `mode` goes to 0 → no step.
- Reset mid-edit: `rst_n = 0` during EDIT_M with `dirty` → next cycle state IDLE, all outputs 0, `blink = 1`, no `load`.

Source files
------------

// File: rtl/time_set_ctrl.sv
// time_set_ctrl: edit-buffer sequencer for setting the clock time in modify mode
module time_set_ctrl #(
  parameter int HOLD_CYCLES   = 50_000_000,
  parameter int REPEAT_CYCLES = 10_000_000,
  parameter int BLINK_CYCLES  = 25_000_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] mode,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       btn_next,
  input  logic [4:0] cur_hour,
  input  logic [5:0] cur_min,
  input  logic [5:0] cur_sec,
  output logic [4:0] set_hour,
  output logic [5:0] set_min,
  output logic [5:0] set_sec,
  output logic       load,
  output logic [1:0] field,
  output logic       blink,
  output logic       editing
);
  typedef enum logic [2:0] {IDLE, EDIT_H, EDIT_M, EDIT_S, COMMIT} state_t;
  state_t state, state_nx;
  logic up_q, dn_q, nx_q;
  logic up_e, dn_e, nx_e;
  logic in_edit, nx_edit, active, edge_step, rep_hit, step, adv;
  logic dirty, dirty_nx, rpt, rpt_nx, blink_nx;
  logic [31:0] rep_cnt, rep_nx, blk_cnt, blk_nx;
  logic [4:0] hour_nx;
  logic [5:0] min_nx, sec_nx;
  // Next-state, edit-buffer, auto-repeat and blink logic
  always_comb begin
    up_e = btn_up & ~up_q;
    dn_e = btn_down & ~dn_q;
    nx_e = btn_next & ~nx_q;
    in_edit = state inside {EDIT_H, EDIT_M, EDIT_S};
    active = in_edit && mode == 4'd0;
    edge_step = (up_e & ~btn_down) | (dn_e & ~btn_up);
    rep_hit = rep_cnt != 32'd0 && (btn_up ^ btn_down) &&
              rep_cnt == (rpt ? 32'(REPEAT_CYCLES) : 32'(HOLD_CYCLES));
    adv = active & nx_e;
    step = active & ~nx_e & (edge_step | rep_hit);
    rep_nx = 32'd0;
    rpt_nx = 1'b0;
    if (active && !nx_e && (btn_up ^ btn_down)) begin
      if (edge_step || rep_hit) begin
        rep_nx = 32'd1;
        rpt_nx = !edge_step;
      end else if (rep_cnt != 32'd0) begin
        rep_nx = rep_cnt + 32'd1;
        rpt_nx = rpt;
      end
    end
    hour_nx = set_hour;
    min_nx = set_min;
    sec_nx = set_sec;
    if (state == IDLE && mode == 4'd0) begin
      hour_nx = cur_hour;
      min_nx = cur_min;
      sec_nx = cur_sec;
    end else if (step && state == EDIT_H)
      hour_nx = btn_up ? (set_hour == 5'd23 ? 5'd0 : set_hour + 5'd1)
                       : (set_hour == 5'd0 ? 5'd23 : set_hour - 5'd1);
    else if (step && state == EDIT_M)
      min_nx = btn_up ? (set_min == 6'd59 ? 6'd0 : set_min + 6'd1)
                      : (set_min == 6'd0 ? 6'd59 : set_min - 6'd1);
    else if (step && state == EDIT_S)
      sec_nx = btn_up ? (set_sec == 6'd59 ? 6'd0 : set_sec + 6'd1)
                      : (set_sec == 6'd0 ? 6'd59 : set_sec - 6'd1);
    dirty_nx = state == IDLE ? 1'b0 : dirty | step;
    state_nx = state;
    case (state)
      IDLE:    state_nx = mode == 4'd0 ? EDIT_H : IDLE;
      EDIT_H:  state_nx = mode != 4'd0 ? (dirty ? COMMIT : IDLE) : nx_e ? EDIT_M : EDIT_H;
      EDIT_M:  state_nx = mode != 4'd0 ? (dirty ? COMMIT : IDLE) : nx_e ? EDIT_S : EDIT_M;
      EDIT_S:  state_nx = mode != 4'd0 ? (dirty ? COMMIT : IDLE) : nx_e ? EDIT_H : EDIT_S;
      default: state_nx = IDLE;
    endcase
    nx_edit = state_nx inside {EDIT_H, EDIT_M, EDIT_S};
    blink_nx = 1'b1;
    blk_nx = 32'd0;
    if (in_edit && nx_edit && !adv && !step) begin
      blink_nx = blk_cnt == 32'(BLINK_CYCLES - 1) ? ~blink : blink;
      blk_nx = blk_cnt == 32'(BLINK_CYCLES - 1) ? 32'd0 : blk_cnt + 32'd1;
    end
  end
  // State, buffer and registered outputs derived from the next state
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      up_q <= 1'b0;
      dn_q <= 1'b0;
      nx_q <= 1'b0;
      dirty <= 1'b0;
      rpt <= 1'b0;
      rep_cnt <= 32'd0;
      blk_cnt <= 32'd0;
      set_hour <= 5'd0;
      set_min <= 6'd0;
      set_sec <= 6'd0;
      load <= 1'b0;
      field <= 2'd0;
      blink <= 1'b1;
      editing <= 1'b0;
    end else begin
      state <= state_nx;
      up_q <= btn_up;
      dn_q <= btn_down;
      nx_q <= btn_next;
      dirty <= dirty_nx;
      rpt <= rpt_nx;
      rep_cnt <= rep_nx;
      blk_cnt <= blk_nx;
      set_hour <= hour_nx;
      set_min <= min_nx;
      set_sec <= sec_nx;
      load <= state_nx == COMMIT;
      field <= state_nx == EDIT_H ? 2'd1 : state_nx == EDIT_M ? 2'd2 :
               state_nx == EDIT_S ? 2'd3 : 2'd0;
      blink <= blink_nx;
      editing <= nx_edit;
    end
  end
endmodule
